// File: rtl/rdm_axis_pkg.sv
// rtl/rdm_axis_pkg.sv - shared RX gate FSM states and default stream geometry
package rdm_axis_pkg;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_FLUSH = 2'd1,
    S_PASS  = 2'd2,
    S_TRUNC = 2'd3
  } rx_state_e;

  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_MAX_BEATS  = 64;

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - 2-entry register slice; outputs and s_tready come straight from flops
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             push;
  logic             out_free;

  // The skid entry absorbs the one beat that arrives while downstream stalls.
  assign s_tready = ~skid_valid;
  assign push     = s_tvalid & ~skid_valid;
  assign out_free = m_tready | ~m_tvalid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (skid_valid) begin
      if (out_free) begin
        m_tvalid   <= 1'b1;
        m_tdata    <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (out_free) begin
      m_tvalid <= push;
      if (push) m_tdata <= s_tdata;
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= s_tdata;
    end
  end

endmodule

// File: rtl/pcie_rx_pkt_gate.sv
// rtl/pcie_rx_pkt_gate.sv - whole-packet ingress gate with truncation and output skid buffer
// Optional statistics counters enabled by PCIE_RX_PKT_GATE_STATS_EN.
module pcie_rx_pkt_gate
  import rdm_axis_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BEATS  = DEF_MAX_BEATS
`ifdef PCIE_RX_PKT_GATE_STATS_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                    RX_clk,
  input  logic                    RX_rst_n,
  input  logic                    driver_ready,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    trunc_flag
`ifdef PCIE_RX_PKT_GATE_STATS_EN
  , output logic [CNT_WIDTH-1:0]  stat_pkt_cnt,
  output logic [CNT_WIDTH-1:0]    stat_drop_cnt,
  output logic [CNT_WIDTH-1:0]    stat_trunc_cnt
`endif
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int BCW        = $clog2(MAX_BEATS);
  localparam int BUF_WIDTH  = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BEATS - 1);

  rx_state_e      state, state_nxt;
  logic [BCW-1:0] beat_cnt, beat_cnt_nxt;
  logic           buf_ready;
  logic           accept;
  logic           push;
  logic           at_limit;
  logic           trunc_evt;
  logic [BUF_WIDTH-1:0] buf_in, buf_out;

  // Only S_PASS can back-pressure; every other state sinks beats freely.
  assign s_axis_tready = RX_rst_n & ((state != S_PASS) | buf_ready);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign at_limit      = (beat_cnt == LAST_BEAT);
  assign buf_in        = {s_axis_tlast | at_limit, s_axis_tkeep, s_axis_tdata};

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    push         = 1'b0;
    trunc_evt    = 1'b0;
    case (state)
      S_WAIT: begin
        if (accept) begin
          if (!s_axis_tlast) state_nxt = S_FLUSH;
        end else if (driver_ready) begin
          state_nxt = S_PASS;
        end
      end
      S_FLUSH, S_TRUNC: begin
        if (accept && s_axis_tlast) state_nxt = driver_ready ? S_PASS : S_WAIT;
      end
      S_PASS: begin
        if (accept) begin
          push = 1'b1;
          if (s_axis_tlast) begin
            beat_cnt_nxt = '0;
            state_nxt    = driver_ready ? S_PASS : S_WAIT;
          end else if (at_limit) begin
            beat_cnt_nxt = '0;
            trunc_evt    = 1'b1;
            state_nxt    = S_TRUNC;
          end else begin
            beat_cnt_nxt = beat_cnt + BCW'(1);
          end
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge RX_clk) begin
    if (!RX_rst_n) begin
      state      <= S_WAIT;
      beat_cnt   <= '0;
      trunc_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (trunc_evt) trunc_flag <= 1'b1;
    end
  end

  axis_skid_buf #(
    .WIDTH(BUF_WIDTH)
  ) u_skid (
    .clk     (RX_clk),
    .resetn  (RX_rst_n),
    .s_tvalid(push),
    .s_tready(buf_ready),
    .s_tdata (buf_in),
    .m_tvalid(m_axis_tvalid),
    .m_tready(m_axis_tready),
    .m_tdata (buf_out)
  );

  assign m_axis_tdata = buf_out[DATA_WIDTH-1:0];
  assign m_axis_tkeep = buf_out[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis_tlast = buf_out[BUF_WIDTH-1];

`ifdef PCIE_RX_PKT_GATE_STATS_EN
  logic drop_evt;
  assign drop_evt = accept & s_axis_tlast & ((state == S_WAIT) | (state == S_FLUSH));

  // All counters saturate rather than wrap.
  always_ff @(posedge RX_clk) begin
    if (!RX_rst_n) begin
      stat_pkt_cnt   <= '0;
      stat_drop_cnt  <= '0;
      stat_trunc_cnt <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast && (stat_pkt_cnt != '1))
        stat_pkt_cnt <= stat_pkt_cnt + CNT_WIDTH'(1);
      if (drop_evt && (stat_drop_cnt != '1))
        stat_drop_cnt <= stat_drop_cnt + CNT_WIDTH'(1);
      if (trunc_evt && (stat_trunc_cnt != '1))
        stat_trunc_cnt <= stat_trunc_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pcie_rx_pkt_gate.sv
// tb/tb_pcie_rx_pkt_gate.sv - directed self-checking bench for pcie_rx_pkt_gate
module tb_pcie_rx_pkt_gate;
  import rdm_axis_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         driver_ready;
  logic         s_tvalid;
  logic         s_tready;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic         s_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic         m_tlast;
  logic         trunc_flag;
`ifdef PCIE_RX_PKT_GATE_STATS_EN
  logic [31:0]  stat_pkt_cnt, stat_drop_cnt, stat_trunc_cnt;
`endif

  int npass = 0;
  int ntotal = 0;
  int vcount = 0;
  logic [31:0] nid = 32'h100;

  logic [255:0] rcv_d[$];
  logic [31:0]  rcv_k[$];
  logic         rcv_l[$];

  pcie_rx_pkt_gate dut (
    .RX_clk       (clk),
    .RX_rst_n     (rst_n),
    .driver_ready (driver_ready),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tlast (s_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tlast (m_tlast),
    .trunc_flag   (trunc_flag)
`ifdef PCIE_RX_PKT_GATE_STATS_EN
    , .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_drop_cnt (stat_drop_cnt),
    .stat_trunc_cnt(stat_trunc_cnt)
`endif
  );

  always #2 clk = ~clk;

  always @(negedge clk) begin
    if (m_tvalid) vcount++;
    if (rst_n && m_tvalid && m_tready) begin
      rcv_d.push_back(m_tdata);
      rcv_k.push_back(m_tkeep);
      rcv_l.push_back(m_tlast);
    end
  end

  function automatic logic [255:0] mk(input logic [31:0] id);
    return {8{id}};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] id, input logic [31:0] keep, input logic last,
                           output int stalls);
    s_tvalid = 1'b1;
    s_tdata  = mk(id);
    s_tkeep  = keep;
    s_tlast  = last;
    stalls   = 0;
    while (!s_tready && stalls < 200) begin
      cyc(1);
      stalls++;
    end
    if (stalls >= 200) begin
      ntotal++;
      $display("FAIL send_timeout id=%h tready stuck low", id);
    end
    cyc(1);
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; driver_ready = 1'b0; m_tready = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    cyc(3);
    ntotal++; if (s_tready !== 1'b0) $display("FAIL rst_s_tready got=%b exp=0", s_tready); else npass++;
    ntotal++; if (m_tvalid !== 1'b0) $display("FAIL rst_m_tvalid got=%b exp=0", m_tvalid); else npass++;
    ntotal++; if (m_tdata !== '0) $display("FAIL rst_m_tdata got=%h exp=0", m_tdata); else npass++;
    ntotal++; if (m_tkeep !== '0) $display("FAIL rst_m_tkeep got=%h exp=0", m_tkeep); else npass++;
    ntotal++; if (m_tlast !== 1'b0) $display("FAIL rst_m_tlast got=%b exp=0", m_tlast); else npass++;
    ntotal++; if (trunc_flag !== 1'b0) $display("FAIL rst_trunc_flag got=%b exp=0", trunc_flag); else npass++;
    rst_n = 1'b1;
    cyc(1);
    ntotal++; if (s_tready !== 1'b1) $display("FAIL wait_s_tready got=%b exp=1", s_tready); else npass++;
  endtask

  task automatic test_drop();
    int st;
    int v0 = vcount;
    for (int i = 0; i < 3; i++) begin
      send_beat(nid, '1, i == 2, st);
      nid++;
      ntotal++; if (st !== 0) $display("FAIL drop_tready beat=%0d stalls=%0d exp=0", i, st); else npass++;
    end
    cyc(3);
    ntotal++; if (vcount !== v0) $display("FAIL drop_m_tvalid cycles=%0d exp=0", vcount - v0); else npass++;
`ifdef PCIE_RX_PKT_GATE_STATS_EN
    ntotal++; if (stat_drop_cnt !== 32'd1) $display("FAIL drop_cnt got=%0d exp=1", stat_drop_cnt); else npass++;
`endif
  endtask

  task automatic test_ready_rise();
    int st;
    int base = rcv_d.size();
    logic [31:0] id0;
    send_beat(nid, '1, 1'b0, st); nid++;
    driver_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_beat(nid, '1, i == 2, st); nid++;
    end
    id0 = nid;
    send_beat(nid, 32'hFFFF_FFFF, 1'b0, st); nid++;
    ntotal++; if (m_tvalid !== 1'b1 || m_tdata !== mk(id0))
      $display("FAIL rise_latency tvalid=%b data=%h exp_data=%h", m_tvalid, m_tdata, mk(id0)); else npass++;
    send_beat(nid, 32'h0000_00FF, 1'b1, st); nid++;
    cyc(3);
    ntotal++; if (rcv_d.size() - base !== 2) $display("FAIL rise_count got=%0d exp=2", rcv_d.size() - base); else npass++;
    for (int i = 0; i < 2; i++) begin
      ntotal++;
      if ({rcv_l[base+i], rcv_k[base+i], rcv_d[base+i]} !==
          {i == 1, (i == 1) ? 32'h0000_00FF : 32'hFFFF_FFFF, mk(id0 + 32'(i))})
        $display("FAIL rise_beat%0d got=%b/%h/%h", i, rcv_l[base+i], rcv_k[base+i], rcv_d[base+i]);
      else npass++;
    end
`ifdef PCIE_RX_PKT_GATE_STATS_EN
    ntotal++; if (stat_drop_cnt !== 32'd2) $display("FAIL rise_drop_cnt got=%0d exp=2", stat_drop_cnt); else npass++;
`endif
  endtask

  task automatic test_trunc();
    int st;
    int base = rcv_d.size();
    logic [31:0] id0 = nid;
    for (int i = 0; i < 70; i++) begin
      send_beat(nid, (i == 63) ? 32'h0F0F_0F0F : 32'hFFFF_FFFF, i == 69, st);
      nid++;
    end
    send_beat(nid, 32'h0000_000F, 1'b1, st); nid++;
    cyc(4);
    ntotal++; if (rcv_d.size() - base !== 65) $display("FAIL trunc_count got=%0d exp=65", rcv_d.size() - base); else npass++;
    for (int i = 0; i < 64; i++) begin
      ntotal++;
      if ({rcv_l[base+i], rcv_k[base+i], rcv_d[base+i]} !==
          {i == 63, (i == 63) ? 32'h0F0F_0F0F : 32'hFFFF_FFFF, mk(id0 + 32'(i))})
        $display("FAIL trunc_beat%0d got=%b/%h/%h", i, rcv_l[base+i], rcv_k[base+i], rcv_d[base+i]);
      else npass++;
    end
    ntotal++;
    if ({rcv_l[base+64], rcv_k[base+64], rcv_d[base+64]} !== {1'b1, 32'h0000_000F, mk(id0 + 32'd70)})
      $display("FAIL trunc_next got=%b/%h/%h", rcv_l[base+64], rcv_k[base+64], rcv_d[base+64]);
    else npass++;
    ntotal++; if (trunc_flag !== 1'b1) $display("FAIL trunc_flag got=%b exp=1", trunc_flag); else npass++;
`ifdef PCIE_RX_PKT_GATE_STATS_EN
    ntotal++; if (stat_trunc_cnt !== 32'd1) $display("FAIL trunc_cnt got=%0d exp=1", stat_trunc_cnt); else npass++;
`endif
  endtask

  task automatic test_back_to_back();
    int st;
    int tot = 0;
    int base = rcv_d.size();
    logic [31:0] id0 = nid;
    for (int i = 0; i < 16; i++) begin
      send_beat(nid, 32'(i * 3 + 1), (i % 8) == 7, st);
      nid++;
      tot += st;
    end
    cyc(2);
    ntotal++; if (tot !== 0) $display("FAIL b2b_throughput stalls=%0d exp=0", tot); else npass++;
    ntotal++; if (rcv_d.size() - base !== 16) $display("FAIL b2b_count got=%0d exp=16", rcv_d.size() - base); else npass++;
    for (int i = 0; i < 16; i++) begin
      ntotal++;
      if ({rcv_l[base+i], rcv_k[base+i], rcv_d[base+i]} !== {(i % 8) == 7, 32'(i * 3 + 1), mk(id0 + 32'(i))})
        $display("FAIL b2b_beat%0d got=%b/%h/%h", i, rcv_l[base+i], rcv_k[base+i], rcv_d[base+i]);
      else npass++;
    end
    base = rcv_d.size();
    id0 = nid;
    fork
      begin
        int st2;
        for (int i = 0; i < 16; i++) begin
          send_beat(nid, 32'(i + 7), (i % 8) == 7, st2);
          nid++;
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          @(posedge clk); #1;
          m_tready = ~m_tready;
        end
      end
    join
    m_tready = 1'b1;
    cyc(4);
    ntotal++; if (rcv_d.size() - base !== 16) $display("FAIL tog_count got=%0d exp=16", rcv_d.size() - base); else npass++;
    for (int i = 0; i < 16; i++) begin
      ntotal++;
      if ({rcv_l[base+i], rcv_k[base+i], rcv_d[base+i]} !== {(i % 8) == 7, 32'(i + 7), mk(id0 + 32'(i))})
        $display("FAIL tog_beat%0d got=%b/%h/%h", i, rcv_l[base+i], rcv_k[base+i], rcv_d[base+i]);
      else npass++;
    end
  endtask

  task automatic test_ready_fall();
    int st;
    int base = rcv_d.size();
    logic [31:0] id0 = nid;
`ifdef PCIE_RX_PKT_GATE_STATS_EN
    logic [31:0] p0 = stat_pkt_cnt;
    logic [31:0] d0 = stat_drop_cnt;
`endif
    for (int i = 0; i < 5; i++) begin
      if (i == 2) driver_ready = 1'b0;
      send_beat(nid, '1, i == 4, st); nid++;
    end
    send_beat(nid, '1, 1'b0, st); nid++;
    send_beat(nid, '1, 1'b1, st); nid++;
    cyc(4);
    ntotal++; if (rcv_d.size() - base !== 5) $display("FAIL fall_count got=%0d exp=5", rcv_d.size() - base); else npass++;
    for (int i = 0; i < 5; i++) begin
      ntotal++;
      if ({rcv_l[base+i], rcv_d[base+i]} !== {i == 4, mk(id0 + 32'(i))})
        $display("FAIL fall_beat%0d got=%b/%h", i, rcv_l[base+i], rcv_d[base+i]);
      else npass++;
    end
`ifdef PCIE_RX_PKT_GATE_STATS_EN
    ntotal++; if (stat_pkt_cnt - p0 !== 32'd1) $display("FAIL fall_pkt_cnt delta=%0d exp=1", stat_pkt_cnt - p0); else npass++;
    ntotal++; if (stat_drop_cnt - d0 !== 32'd1) $display("FAIL fall_drop_cnt delta=%0d exp=1", stat_drop_cnt - d0); else npass++;
`endif
    driver_ready = 1'b1;
    cyc(2);
  endtask

  task automatic test_rst_mid();
    int st;
    int base;
    logic [31:0] id0;
    m_tready = 1'b0;
    send_beat(nid, '1, 1'b0, st); nid++;
    send_beat(nid, '1, 1'b0, st); nid++;
    ntotal++; if (s_tready !== 1'b0) $display("FAIL full_s_tready got=%b exp=0", s_tready); else npass++;
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    ntotal++; if (m_tvalid !== 1'b0) $display("FAIL mrst_m_tvalid got=%b exp=0", m_tvalid); else npass++;
    ntotal++; if (trunc_flag !== 1'b0) $display("FAIL mrst_trunc_flag got=%b exp=0", trunc_flag); else npass++;
    ntotal++; if (dut.state !== S_WAIT) $display("FAIL mrst_state got=%0d exp=%0d", dut.state, S_WAIT); else npass++;
    base = rcv_d.size();
    m_tready = 1'b1;
    cyc(3);
    ntotal++; if (rcv_d.size() - base !== 0) $display("FAIL mrst_leak got=%0d exp=0", rcv_d.size() - base); else npass++;
    id0 = nid;
    for (int i = 0; i < 3; i++) begin
      send_beat(nid, 32'h1234_5678, i == 2, st); nid++;
    end
    cyc(3);
    ntotal++; if (rcv_d.size() - base !== 3) $display("FAIL mrst_count got=%0d exp=3", rcv_d.size() - base); else npass++;
    for (int i = 0; i < 3; i++) begin
      ntotal++;
      if ({rcv_l[base+i], rcv_k[base+i], rcv_d[base+i]} !== {i == 2, 32'h1234_5678, mk(id0 + 32'(i))})
        $display("FAIL mrst_beat%0d got=%b/%h/%h", i, rcv_l[base+i], rcv_k[base+i], rcv_d[base+i]);
      else npass++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_drop();
    test_ready_rise();
    test_trunc();
    test_back_to_back();
    test_ready_fall();
    test_rst_mid();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/pcie_rx_pkt_gate.md
Name: pcie_rx_pkt_gate

Overview:
- Ingress stage between the PCIe DMA H2C AXI-Stream master and the RDM core RX port, on the 250 MHz PCIe user clock.
- Forwards only whole packets, and only while the driver is ready.
- Truncates packets longer than MAX_BEATS and drops the excess.
- Registered 2-entry skid buffer at the output, so timing toward the RDM core is closed with full throughput.

Parameters:
- DATA_WIDTH, 256, AXIS data width in bits; tkeep width = DATA_WIDTH/8.
- MAX_BEATS, 64, maximum beats per forwarded packet (2 KiB at 256 bits); must be ≥2.
- CNT_WIDTH, 32, width of statistics counters.

Ports:
- RX_clk  in  1  PCIe user clock; sole clock.
- RX_rst_n  in  1  synchronous, active-low reset.
- driver_ready  in  1  PCIe link-up level; async-free, already in RX_clk domain.
- s_axis_tvalid  in  1  from DMA H2C.
- s_axis_tready  out  1  to DMA H2C.
- s_axis_tdata  in  DATA_WIDTH.
- s_axis_tkeep  in  DATA_WIDTH/8.
- s_axis_tlast  in  1.
- m_axis_tvalid  out  1  to RDM RX.
- m_axis_tready  in  1.
- m_axis_tdata  out  DATA_WIDTH.
- m_axis_tkeep  out  DATA_WIDTH/8.
- m_axis_tlast  out  1.
- trunc_flag  out  1  sticky; set on first truncation, cleared only by reset.

Behaviour:
- Reset: all state cleared on RX_clk edge with RX_rst_n=0.
  - Outputs after reset: m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, trunc_flag=0, s_axis_tready=0 during reset, beat counter=0, FSM=S_WAIT, skid buffer empty.
  - Reset mid-packet discards all buffered beats; the input is treated as at a packet boundary afterwards.
- FSM states: S_WAIT, S_FLUSH, S_PASS, S_TRUNC. Transitions are evaluated per accepted input beat (s_axis_tvalid & s_axis_tready).
- S_WAIT:
  - s_axis_tready=1; beats are discarded.
  - driver_ready=1 and no beat accepted this cycle → S_PASS.
  - Beat accepted with tlast=0 → S_FLUSH.
  - Beat accepted with tlast=1 → stay in S_WAIT.
- S_FLUSH:
  - s_axis_tready=1; discard until a beat with tlast is accepted.
  - Then → S_PASS if driver_ready=1, else → S_WAIT.
- S_PASS:
  - s_axis_tready = skid buffer not full; beats are forwarded; beat counter increments per accepted beat.
  - Accepted tlast → counter=0; stay in S_PASS if driver_ready=1, else → S_WAIT.
  - Falling driver_ready mid-packet does not truncate; the packet completes normally.
  - Accepted beat with counter == MAX_BEATS-1 and tlast=0 → forward the beat with m tlast forced to 1 (tkeep unchanged), set trunc_flag, counter=0, → S_TRUNC.
- S_TRUNC:
  - s_axis_tready=1; discard until accepted tlast.
  - Then → S_PASS if driver_ready=1, else → S_WAIT.
- Skid buffer:
  - 2 entries; m_axis_* driven directly from flops.
  - Latency input→output is 1 cycle when empty.
  - Sustains 1 beat/cycle with m_axis_tready=1.
  - s_axis_tready in S_PASS is registered: it deasserts when the second entry fills, so no beat is lost.
  - m_axis_tdata/tkeep/tlast remain stable while m_axis_tvalid=1 and m_axis_tready=0.
- Simultaneous push and pop on a full buffer is allowed only if tready was high the prior cycle. The registered tready guarantees this.
- Counter width is clog2(MAX_BEATS); it never wraps past MAX_BEATS-1.

Optional Feature:
- Macro: PCIE_RX_PKT_GATE_STATS_EN.
- When defined, adds outputs:
  - stat_pkt_cnt  out  CNT_WIDTH: packets forwarded, incremented on output tlast handshake.
  - stat_drop_cnt  out  CNT_WIDTH: packets discarded in S_WAIT or S_FLUSH, incremented on the discarded tlast.
  - stat_trunc_cnt  out  CNT_WIDTH: truncation events.
- All three counters saturate at all-ones, reset to 0, and update 1 cycle after the event.
- When undefined: these ports and counters do not exist, and the remaining behaviour is identical.

Decomposition:
- Shared package rdm_axis_pkg holds:
  - FSM state enum: S_WAIT, S_FLUSH, S_PASS, S_TRUNC.
  - Default DATA_WIDTH constant 256.
  - Default MAX_BEATS constant 64.
- One sub-module: axis_skid_buf (2-entry register slice, parameterized width, same clock and reset). The top holds the FSM, counters and gating.

Test Plan:
- driver_ready=0, send 3-beat packet → s_axis_tready=1 throughout, m_axis_tvalid never 1, stat_drop_cnt=1.
- driver_ready rises during beat 2 of a 4-beat packet → that packet is fully dropped; the next 2-beat packet appears on m_axis with data intact, and first-beat latency is 1 cycle.
- MAX_BEATS=64, send 70-beat packet → 64 beats out with tlast on beat 64, 6 beats dropped, trunc_flag=1, stat_trunc_cnt=1; a following 1-beat packet passes unaltered.
- Back-to-back 8-beat packets with m_axis_tready=1 → 1 beat/cycle throughput; with m_axis_tready toggling 1010… → no loss, duplication or reordering against the scoreboard.
- driver_ready falls at beat 3 of a 5-beat packet → all 5 beats forwarded; the next packet is dropped; stat_pkt_cnt increments by 1.
- RX_rst_n asserted for 1 cycle with 2 beats buffered mid-packet → m_axis_tvalid=0 the next cycle, trunc_flag=0, FSM in S_WAIT; a clean packet afterwards forwards correctly.
